des_sbox_seq: RTL and testbench

- Parametrised, sequential DES substitution engine that replaces hard-wired single-box lookups.
- Holds NBOX run-time loadable 64x4 substitution tables and processes a 6*NBOX-bit expanded word, LANES boxes per cycle, into a 4*NBOX-bit result.
- Uses a valid/ready handshake on both sides.
- Sits between the E-expansion/key-XOR stage and the P-permutation in the round datapath.

---
 rtl/des_sbox_seq_if.sv | 22 ++
 rtl/des_sbox_seq.sv | 113 +++++++++++
 tb/tb_des_sbox_seq.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_sbox_seq_if.sv
// Stream handshake bundle for the sequential DES substitution engine.
// Bit 1 of each word is its leftmost (most significant) bit.
interface des_sbox_seq_if #(
    parameter int NBOX = 8
) ();
    logic            in_valid;
    logic            in_ready;
    logic [1:6*NBOX] s_in;
    logic            out_valid;
    logic            out_ready;
    logic [1:4*NBOX] s_out;

    modport master (
        output in_valid, s_in, out_ready,
        input  in_ready, out_valid, s_out
    );

    modport slave (
        input  in_valid, s_in, out_ready,
        output in_ready, out_valid, s_out
    );
endinterface

// File: rtl/des_sbox_seq.sv
// Sequential DES S-box engine: NBOX run-time loadable 64x4 tables, LANES
// boxes resolved per cycle, valid/ready on both the input and output side.
module des_sbox_seq #(
    parameter int NBOX  = 8,
    parameter int LANES = 1,
    parameter int BW    = (NBOX > 1) ? $clog2(NBOX) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tbl_we,
    input  logic [BW-1:0] tbl_box,
    input  logic [5:0]    tbl_addr,
    input  logic [3:0]    tbl_data,
    output logic          tbl_wr_err,
    des_sbox_seq_if.slave bus,
    output logic          busy
);
    localparam int NSTEP = NBOX / LANES;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);
    localparam logic [BW:0]   BOX_LIMIT = (BW + 1)'(NBOX);

    if (NBOX < 1 || LANES < 1 || (NBOX % LANES) != 0) begin : g_param_check
        $error("des_sbox_seq: NBOX must be >= 1 and an exact multiple of LANES");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] counter;
    logic          accept;
    logic          wr_ok;

    logic [3:0]    tbl      [NBOX][64];
    logic [5:0]    in_slice [NBOX];
    logic [5:0]    in_box   [NBOX];
    logic [3:0]    out_box  [NBOX];
    logic [BW-1:0] lane_box [LANES];
    logic [3:0]    lane_res [LANES];

    assign busy          = (state != IDLE);
    assign bus.in_ready  = rst_n & ~busy & ~tbl_we;
    assign bus.out_valid = (state == DONE);
    assign accept        = bus.in_valid & bus.in_ready;
    assign wr_ok         = tbl_we & ~busy & ({1'b0, tbl_box} < BOX_LIMIT);

    for (genvar k = 0; k < NBOX; k++) begin : g_box
        assign in_slice[k]            = bus.s_in[6*k+1 +: 6];
        assign bus.s_out[4*k+1 +: 4] = out_box[k];
    end

    // Each lane addresses its table with {outer bits, inner four bits} of its slice.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_box[l] = BW'(int'(counter) * LANES + l);
        assign lane_res[l] = tbl[lane_box[l]][{in_box[lane_box[l]][5],
                                               in_box[lane_box[l]][0],
                                               in_box[lane_box[l]][4:1]}];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (counter == LAST_STEP) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Table writes only land while idle, so they can never race a lookup.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter    <= '0;
            tbl_wr_err <= 1'b0;
            for (int k = 0; k < NBOX; k++) begin
                out_box[k] <= '0;
                for (int e = 0; e < 64; e++) begin
                    tbl[k][e] <= '0;
                end
            end
        end else begin
            tbl_wr_err <= tbl_we & ~wr_ok;
            if (wr_ok) begin
                tbl[tbl_box][tbl_addr] <= tbl_data;
            end
            if (accept) begin
                counter <= '0;
                for (int k = 0; k < NBOX; k++) begin
                    in_box[k] <= in_slice[k];
                end
            end
            if (state == RUN) begin
                counter <= (counter == LAST_STEP) ? '0 : counter + 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    out_box[lane_box[l]] <= lane_res[l];
                end
            end
        end
    end
endmodule

// File: tb/tb_des_sbox_seq.sv
// Randomised self-checking bench for des_sbox_seq against an arithmetic
// S-box model; runs 8x1, 8x4 and 6x2 configurations side by side.
module tb_des_sbox_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       tbl_we;
    logic [2:0] tbl_box;
    logic [5:0] tbl_addr;
    logic [3:0] tbl_data;
    logic       err0, err4, err6;
    logic       busy0, busy4, busy6;

    int n_checks = 0;
    int n_fail   = 0;
    int ref_tbl [8][64];
    int fips [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
          0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
          15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
          3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
          13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
          13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
          1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
          13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
          3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
          14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
          11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
          10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
          4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
          13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
          6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
          1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
          2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    des_sbox_seq_if #(.NBOX(8)) bus0 ();
    des_sbox_seq_if #(.NBOX(8)) bus4 ();
    des_sbox_seq_if #(.NBOX(6)) bus6 ();

    des_sbox_seq #(.NBOX(8), .LANES(1)) dut (
        .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_box(tbl_box),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_wr_err(err0),
        .bus(bus0), .busy(busy0)
    );

    des_sbox_seq #(.NBOX(8), .LANES(4)) dut_l4 (
        .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_box(tbl_box),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_wr_err(err4),
        .bus(bus4), .busy(busy4)
    );

    des_sbox_seq #(.NBOX(6), .LANES(2)) dut_n6 (
        .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_box(tbl_box),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_wr_err(err6),
        .bus(bus6), .busy(busy6)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] rand48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[47:0];
    endfunction

    function automatic logic [47:0] set_slice(input logic [47:0] w, input int k, input logic [5:0] v);
        int sh;
        sh = 6 * (7 - k);
        w = w & ~(48'h3F << sh);
        w = w | ({42'b0, v} << sh);
        return w;
    endfunction

    // Row is the outer bit pair of each 6-bit group, column the inner four.
    function automatic logic [31:0] model(input logic [47:0] w);
        logic [31:0] res;
        res = '0;
        for (int k = 0; k < 8; k++) begin
            int s;
            int idx;
            s   = int'((w >> (6 * (7 - k))) & 48'h3F);
            idx = ((s >> 5) & 1) * 32 + (s & 1) * 16 + ((s >> 1) & 15);
            res = res | (32'(ref_tbl[k][idx]) << (4 * (7 - k)));
        end
        return res;
    endfunction

    task automatic clear_ref();
        for (int k = 0; k < 8; k++) begin
            for (int e = 0; e < 64; e++) begin
                ref_tbl[k][e] = 0;
            end
        end
    endtask

    task automatic write_entry(input int box, input int addr, input int data);
        tbl_we   = 1'b1;
        tbl_box  = 3'(box);
        tbl_addr = 6'(addr);
        tbl_data = 4'(data);
        if (box < 8) ref_tbl[box][addr] = data;
        @(negedge clk);
    endtask

    task automatic load_box(input int box, input int src);
        bit err_seen;
        err_seen = 1'b0;
        for (int a = 0; a < 64; a++) begin
            write_entry(box, a, fips[src][a]);
            if (err0) err_seen = 1'b1;
        end
        tbl_we = 1'b0;
        checkOutput("load_err", err_seen, 1'b0);
    endtask

    task automatic applyStimulus(input logic [47:0] w, input bit use4, output logic [31:0] got0);
        logic [31:0] exp;
        logic [31:0] got4;
        int lat0;
        int lat4;
        exp  = model(w);
        got0 = '0;
        got4 = '0;
        lat0 = -1;
        lat4 = -1;
        bus0.s_in = w;
        bus0.in_valid = 1'b1;
        if (use4) begin
            bus4.s_in = w;
            bus4.in_valid = 1'b1;
        end
        #1;
        checkOutput("in_ready", bus0.in_ready, 1'b1);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        bus0.s_in = ~w;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus0.out_valid && lat0 < 0) begin
                lat0 = c;
                got0 = bus0.s_out;
            end
            if (bus4.out_valid && lat4 < 0) begin
                lat4 = c;
                got4 = bus4.s_out;
            end
        end
        checkOutput("latency", lat0, 8);
        checkOutput("s_out", got0, exp);
        checkOutput("s_out_hold", bus0.s_out, exp);
        if (use4) begin
            checkOutput("latency_l4", lat4, 2);
            checkOutput("s_out_l4", got4, exp);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && (busy0 || busy4); c++) @(negedge clk);
        checkOutput("drain_idle", {busy0, busy4}, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [47:0] w;
        logic [31:0] exp;
        logic [31:0] got;
        bit          seen;
        int          first;
        int          second;

        rst_n    = 1'b0;
        tbl_we   = 1'b0;
        tbl_box  = '0;
        tbl_addr = '0;
        tbl_data = '0;
        bus0.in_valid = 1'b1;  bus0.out_ready = 1'b1;  bus0.s_in = '0;
        bus4.in_valid = 1'b1;  bus4.out_ready = 1'b1;  bus4.s_in = '0;
        bus6.in_valid = 1'b0;  bus6.out_ready = 1'b1;  bus6.s_in = '0;
        clear_ref();

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", bus0.in_ready, 1'b0);
        checkOutput("rst_out_valid", bus0.out_valid, 1'b0);
        checkOutput("rst_s_out", bus0.s_out, 32'h0);
        checkOutput("rst_busy", busy0, 1'b0);
        checkOutput("rst_wr_err", err0, 1'b0);
        bus0.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(rand48(), 1'b1, got);
        checkOutput("empty_table", got, 32'h0);

        $display("[TB] S3 into box 2");
        load_box(2, 2);
        applyStimulus(set_slice(rand48(), 2, 6'b000000), 1'b1, got);
        checkOutput("s3_000000", (got >> 20) & 32'hF, 10);
        applyStimulus(set_slice(rand48(), 2, 6'b100001), 1'b0, got);
        checkOutput("s3_100001", (got >> 20) & 32'hF, 1);
        applyStimulus(set_slice(rand48(), 2, 6'b000001), 1'b0, got);
        checkOutput("s3_000001", (got >> 20) & 32'hF, 13);
        applyStimulus(set_slice(rand48(), 2, 6'b111111), 1'b0, got);
        checkOutput("s3_111111", (got >> 20) & 32'hF, 12);

        $display("[TB] full FIPS table set");
        for (int b = 0; b < 8; b++) load_box(b, b);
        applyStimulus(48'h0, 1'b1, got);
        checkOutput("full_zero_word", got, 32'hEFA72C4D);
        for (int i = 0; i < 6; i++) applyStimulus(rand48(), 1'b1, got);

        $display("[TB] backpressure");
        bus0.out_ready = 1'b0;
        w   = rand48();
        exp = model(w);
        bus0.s_in = w;
        bus0.in_valid = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        bus0.s_in = ~w;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = bus0.out_valid;
        end
        checkOutput("bp_valid", seen, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp_s_out", bus0.s_out, exp);
            checkOutput("bp_in_ready", bus0.in_ready, 1'b0);
            checkOutput("bp_busy", busy0, 1'b1);
        end
        bus0.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_busy", busy0, 1'b0);
        checkOutput("bp_release_valid", bus0.out_valid, 1'b0);
        checkOutput("bp_release_s_out", bus0.s_out, exp);

        bus0.s_in = rand48();
        bus0.in_valid = 1'b1;
        first  = -1;
        second = -1;
        for (int c = 0; c < 30 && second < 0; c++) begin
            #1;
            if (bus0.in_ready) begin
                if (first < 0) first = c;
                else second = c;
            end
            @(negedge clk);
        end
        bus0.in_valid = 1'b0;
        checkOutput("accept_spacing", second - first, 10);
        drain();

        $display("[TB] write while running");
        w = set_slice(rand48(), 3, 6'b001010);
        bus0.s_in = w;  bus0.in_valid = 1'b1;
        bus4.s_in = w;  bus4.in_valid = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        tbl_we   = 1'b1;
        tbl_box  = 3'd3;
        tbl_addr = 6'd5;
        tbl_data = 4'(ref_tbl[3][5] ^ 15);
        @(negedge clk);
        tbl_we = 1'b0;
        checkOutput("run_wr_err", err0, 1'b1);
        checkOutput("run_wr_err_l4", err4, 1'b1);
        @(negedge clk);
        checkOutput("run_wr_err_pulse", err0, 1'b0);
        drain();
        applyStimulus(w, 1'b1, got);
        checkOutput("run_wr_unchanged", (got >> 16) & 32'hF, 32'(fips[3][5]));

        $display("[TB] out-of-range box");
        write_entry(7, 9, 10);
        tbl_we = 1'b0;
        checkOutput("n6_box7_err", err6, 1'b1);
        checkOutput("n8_box7_ok", err0, 1'b0);
        @(negedge clk);
        checkOutput("n6_box7_pulse", err6, 1'b0);

        w = set_slice(rand48(), 1, 6'b100010);
        bus0.s_in = w;
        bus0.in_valid = 1'b1;
        tbl_we   = 1'b1;
        tbl_box  = 3'd1;
        tbl_addr = 6'd33;
        tbl_data = 4'd7;
        ref_tbl[1][33] = 7;
        #1;
        checkOutput("we_blocks_ready", bus0.in_ready, 1'b0);
        @(negedge clk);
        checkOutput("we_no_accept", busy0, 1'b0);
        tbl_we = 1'b0;
        applyStimulus(w, 1'b0, got);
        checkOutput("we_applied", (got >> 24) & 32'hF, 7);

        $display("[TB] reset mid-run");
        w = rand48();
        bus0.s_in = w;  bus0.in_valid = 1'b1;
        bus4.s_in = w;  bus4.in_valid = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_ref();
        checkOutput("midrst_busy", busy0, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus0.out_valid) seen = 1'b1;
        end
        checkOutput("midrst_no_valid", seen, 1'b0);
        checkOutput("midrst_s_out", bus0.s_out, 32'h0);
        applyStimulus(rand48(), 1'b1, got);
        checkOutput("midrst_tbl_clear", got, 32'h0);

        $display("[TB] random tables");
        for (int i = 0; i < 40; i++) begin
            write_entry(int'($urandom_range(7, 0)), int'($urandom_range(63, 0)), int'($urandom_range(15, 0)));
        end
        tbl_we = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(rand48(), 1'b1, got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
